// File: rtl/game_pkg.sv
// Shared types for the Life engine and its display stage.
// Board layout: row r occupies bits [8r+7:8r], column c is bit c of that row.
package game_pkg;

    localparam int GRID_W = 64;
    localparam int ROW_W  = 8;

    typedef logic [GRID_W-1:0] grid_t;
    typedef logic [ROW_W-1:0]  row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        BLANK = 2'd3
    } scan_state_t;

endpackage

// File: rtl/led_matrix_scan_popcount64.sv
// Combinational population count of a 64-bit board.
// The result is 7 bits wide because a full board holds 64 live cells.
module popcount64
    import game_pkg::*;
(
    input  logic [GRID_W-1:0] v,
    output logic [6:0]        count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < GRID_W; i++) begin
            count = count + {6'b0, v[i]};
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed 8x8 LED scanner with a double-buffered board snapshot.
// The displayed buffer only changes in LOAD, so a frame never tears.
module led_matrix_scan
    import game_pkg::*;
#(
    parameter int DWELL          = 4,
    parameter int BLANK          = 1,
    parameter bit ROW_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid,
    input  logic        grid_valid,
    input  logic        enable,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_start,
    output logic [6:0]  alive_count,
    output logic [1:0]  state_dbg
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_t      state, state_n;
    logic [2:0]       row, row_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    grid_t            shadow, disp, disp_n;
    logic             pending;

    row_t             row_sel_q, row_sel_d;
    row_t             col_q, col_d;
    logic             fs_q, fs_d;
    logic [6:0]       alive_q, alive_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; end of row 7 is the only point enable is consulted mid-scan.
    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (enable) state_n = LOAD;
            end
            LOAD: begin
                state_n = game_pkg::DWELL;
                row_n   = '0;
                cnt_n   = '0;
            end
            game_pkg::DWELL: begin
                if (cnt == DWELL_LAST) begin
                    cnt_n = '0;
                    if (BLANK > 0) begin
                        state_n = game_pkg::BLANK;
                    end else if (row != 3'd7) begin
                        row_n = row + 3'd1;
                    end else begin
                        state_n = enable ? LOAD : IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            game_pkg::BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_n = '0;
                    if (row != 3'd7) begin
                        row_n   = row + 3'd1;
                        state_n = game_pkg::DWELL;
                    end else begin
                        state_n = enable ? LOAD : IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A strobe landing in LOAD bypasses the shadow so the freshest board is shown.
    always_comb begin
        disp_n = disp;
        if (state == LOAD) begin
            if (grid_valid)   disp_n = grid;
            else if (pending) disp_n = shadow;
        end
    end

    popcount64 u_popcount (
        .v     (disp_n),
        .count (alive_d)
    );

    // Output decode from next state so registered outputs line up with the state.
    always_comb begin
        row_sel_d = '0;
        col_d     = '0;
        fs_d      = (state_n == LOAD);
        if (state_n == game_pkg::DWELL) begin
            row_sel_d = row_t'(8'd1 << row_n);
            col_d     = disp_n[{row_n, 3'b000} +: ROW_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow    <= '0;
            disp      <= '0;
            pending   <= 1'b0;
            row_sel_q <= '0;
            col_q     <= '0;
            fs_q      <= 1'b0;
            alive_q   <= '0;
        end else begin
            disp <= disp_n;
            if (grid_valid) shadow <= grid;
            if (state == LOAD)   pending <= 1'b0;
            else if (grid_valid) pending <= 1'b1;
            row_sel_q <= row_sel_d;
            col_q     <= col_d;
            fs_q      <= fs_d;
            alive_q   <= alive_d;
        end
    end

    assign row_sel     = ROW_ACTIVE_LOW ? ~row_sel_q : row_sel_q;
    assign col_data    = col_q;
    assign frame_start = fs_q;
    assign alive_count = alive_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with DWELL=4, BLANK=1 (41-cycle frame).
// Expected values are hand-derived from the board contents driven by each step.
module tb_led_matrix_scan;
    import game_pkg::*;

    logic        clk;
    logic        reset;
    logic [63:0] grid;
    logic        grid_valid;
    logic        enable;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_start;
    logic [6:0]  alive_count;
    logic [1:0]  state_dbg;

    int n_vec  = 0;
    int n_fail = 0;

    led_matrix_scan #(
        .DWELL          (4),
        .BLANK          (1),
        .ROW_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .grid        (grid),
        .grid_valid  (grid_valid),
        .enable      (enable),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start),
        .alive_count (alive_count),
        .state_dbg   (state_dbg)
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_row_sel"}, row_sel, 8'h00);
        chk({tag, "_col"}, col_data, 8'h00);
    endtask

    // Advance into a LOAD cycle; optionally strobe a board during it.
    task automatic do_load(input bit strobe, input logic [63:0] sg);
        tick;
        grid_valid = 1'b0;
        chk("load_fs", frame_start, 1'b1);
        chk("load_state", state_dbg, LOAD);
        chk_dark("load");
        if (strobe) begin
            grid       = sg;
            grid_valid = 1'b1;
        end
    endtask

    // One row: four lit cycles then one blank; actions fire in the first lit cycle.
    task automatic check_row(input int r, input logic [7:0] exp_col, input logic [6:0] exp_alive,
                             input bit strobe, input logic [63:0] sg, input bit drop, input bit rst);
        logic [7:0] exp_sel;
        exp_sel = 8'h01 << r;
        tick;
        grid_valid = 1'b0;
        chk("lit_row_sel", row_sel, exp_sel);
        chk("lit_col", col_data, exp_col);
        chk("lit_fs", frame_start, 1'b0);
        chk("lit_alive", alive_count, exp_alive);
        if (strobe) begin
            grid       = sg;
            grid_valid = 1'b1;
        end
        if (drop) enable = 1'b0;
        if (rst) begin
            reset = 1'b1;
            return;
        end
        for (int k = 1; k < 4; k++) begin
            tick;
            grid_valid = 1'b0;
            chk("dwell_row_sel", row_sel, exp_sel);
            chk("dwell_col", col_data, exp_col);
        end
        tick;
        chk_dark("blank");
        chk("blank_state", state_dbg, BLANK);
    endtask

    task automatic check_frame(input logic [63:0] g, input logic [6:0] a,
                               input int strobe_row, input logic [63:0] sg,
                               input int drop_row, input int rst_row);
        logic [7:0] c;
        for (int r = 0; r < 8; r++) begin
            c = g[8*r +: 8];
            check_row(r, c, a, r == strobe_row, sg, r == drop_row, r == rst_row);
            if (r == rst_row) break;
        end
    endtask

    initial begin
        int gap;
        reset      = 1'b1;
        enable     = 1'b1;
        grid       = '0;
        grid_valid = 1'b0;

        // Reset held three cycles: dark and idle throughout
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_dark("rst");
            chk("rst_fs", frame_start, 1'b0);
            chk("rst_alive", alive_count, 7'd0);
            chk("rst_state", state_dbg, IDLE);
        end

        // Strobe 0x81 in the release cycle; LOAD follows and takes it from the shadow
        reset      = 1'b0;
        grid       = 64'h0000_0000_0000_0081;
        grid_valid = 1'b1;
        do_load(1'b0, '0);

        // Frame A: 0x81 on row 0; all-ones strobe during row 3 must not tear the frame
        check_frame(64'h0000_0000_0000_0081, 7'd2, 3, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);

        // Frame B: full board
        do_load(1'b0, '0);
        check_frame(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, -1, '0, -1, -1);

        // Frame C: strobe in the LOAD cycle is shown immediately
        do_load(1'b1, 64'h8000_0000_0000_0000);
        check_frame(64'h8000_0000_0000_0000, 7'd1, -1, '0, -1, -1);

        // Frame D: enable dropped during row 2; rows 3-7 still scanned
        do_load(1'b0, '0);
        check_frame(64'h8000_0000_0000_0000, 7'd1, -1, '0, 2, -1);

        for (int i = 0; i < 4; i++) begin
            tick;
            chk("idle_state", state_dbg, IDLE);
            chk("idle_fs", frame_start, 1'b0);
            chk_dark("idle");
        end

        // Re-enable: LOAD on the next cycle, then frame_start every 41 cycles
        enable = 1'b1;
        do_load(1'b0, '0);
        gap = 0;
        do begin
            tick;
            gap++;
        end while (!frame_start && gap < 60);
        chk("fs_spacing", gap, 41);
        chk("fs_state", state_dbg, LOAD);

        // Frame F: strobe during row 2 leaves a pending board; reset in row 5 discards it
        check_frame(64'h8000_0000_0000_0000, 7'd1, 2, 64'h0000_00FF_0000_0000, -1, 5);
        tick;
        reset = 1'b0;
        chk_dark("midrst");
        chk("midrst_state", state_dbg, IDLE);
        chk("midrst_alive", alive_count, 7'd0);
        chk("midrst_fs", frame_start, 1'b0);

        // Next frame shows the cleared buffer, not the discarded strobe
        do_load(1'b0, '0);
        check_frame(64'h0, 7'd0, -1, '0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
